// File: rtl/riscv_alu_seq_if.sv
// Request/result bundle between the decoder (master) and riscv_alu_seq (slave).
interface riscv_alu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_alu_ctrl;
  logic [XLEN-1:0] i_alu_a;
  logic [XLEN-1:0] i_alu_b;
  logic            i_kill;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_out;
  logic            o_alu_zero;
  logic            o_illegal;

  modport master (
    output i_valid, i_alu_ctrl, i_alu_a, i_alu_b, i_kill, i_ready,
    input  o_ready, o_valid, o_alu_out, o_alu_zero, o_illegal
  );

  modport slave (
    input  i_valid, i_alu_ctrl, i_alu_a, i_alu_b, i_kill, i_ready,
    output o_ready, o_valid, o_alu_out, o_alu_zero, o_illegal
  );
endinterface

// File: rtl/riscv_alu_seq.sv
// Sequential RV32/RV64 execute unit: registered base ALU ops (1-cycle latency) and
// iterative M-extension multiply/divide (XLEN+1 cycles) behind a valid/ready handshake.
// Build option: define RISCV_ALU_MULDIV_EN to include the multiplier/divider; without it
// M requests complete in one cycle flagged illegal with a zero result.
module riscv_alu_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic            i_clk,
  input logic            i_rst,
  riscv_alu_seq_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned CNT_W   = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    out_q, out_d;
  logic               illegal_q, illegal_d;
  logic               ready;
  logic               accept;
  logic [XLEN-1:0]    base_res;
  logic               base_ill;
  logic [SHAMT_W-1:0] shamt;

  assign ready          = (state_q == IDLE) || ((state_q == DONE) && bus.i_ready);
  assign accept         = bus.i_valid && ready && !bus.i_kill;
  assign bus.o_ready    = ready;
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_alu_out  = out_q;
  assign bus.o_alu_zero = (out_q == '0);
  assign bus.o_illegal  = illegal_q;

  // Single-cycle base ALU result, computed straight from the request operands
  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    shamt    = bus.i_alu_b[SHAMT_W-1:0];
    case (bus.i_alu_ctrl[3:0])
      4'd0:    base_res = bus.i_alu_a + bus.i_alu_b;
      4'd1:    base_res = bus.i_alu_a - bus.i_alu_b;
      4'd2:    base_res = bus.i_alu_a ^ bus.i_alu_b;
      4'd3:    base_res = bus.i_alu_a | bus.i_alu_b;
      4'd4:    base_res = bus.i_alu_a & bus.i_alu_b;
      4'd5:    base_res = bus.i_alu_a << shamt;
      4'd6:    base_res = bus.i_alu_a >> shamt;
      4'd7:    base_res = $unsigned($signed(bus.i_alu_a) >>> shamt);
      4'd8:    base_res = {{(XLEN-1){1'b0}}, $signed(bus.i_alu_a) < $signed(bus.i_alu_b)};
      4'd9:    base_res = {{(XLEN-1){1'b0}}, bus.i_alu_a < bus.i_alu_b};
      default: base_ill = 1'b1;
    endcase
  end

`ifdef RISCV_ALU_MULDIV_EN
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, m_res;

  // acc_q is shared: multiply keeps {partial high, remaining multiplier bits},
  // divide keeps {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  // opnd_q holds |A| (multiplicand) or |B| (divisor).
  always_comb begin
    is_div    = f3_q[2];
    a_sgn     = (f3_q != 3'd3) && (f3_q != 3'd5) && (f3_q != 3'd7);
    b_sgn     = a_sgn && (f3_q != 3'd2);
    a_neg     = a_sgn && a_q[XLEN-1];
    b_neg     = b_sgn && b_q[XLEN-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div) begin
      if (div_diff[XLEN]) acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod  = (a_neg ^ b_neg) ? -acc_step : acc_step;
    quo   = (a_neg ^ b_neg) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem   = a_neg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    m_res = '0;
    case (f3_q)
      3'd0:                m_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    m_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          m_res = (b_q == '0) ? '1  : quo;
      default:             m_res = (b_q == '0) ? a_q : rem;
    endcase
  end
`endif

  // Next-state, result and iteration-register update
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    illegal_d = illegal_q;
`ifdef RISCV_ALU_MULDIV_EN
    f3_d   = f3_q;
    a_d    = a_q;
    b_d    = b_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
`endif
    case (state_q)
      DONE: if (bus.i_ready) state_d = IDLE;
`ifdef RISCV_ALU_MULDIV_EN
      BUSY: begin
        if (cnt_q == '0) begin
          opnd_d = is_div ? b_mag : a_mag;
          acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          cnt_d  = CNT_W'(1);
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN)) begin
            state_d   = DONE;
            out_d     = m_res;
            illegal_d = 1'b0;
            cnt_d     = '0;
          end
        end
      end
`endif
      default: ;
    endcase
    if (accept) begin
      if (bus.i_alu_ctrl[4]) begin
`ifdef RISCV_ALU_MULDIV_EN
        state_d = BUSY;
        f3_d    = bus.i_alu_ctrl[2:0];
        a_d     = bus.i_alu_a;
        b_d     = bus.i_alu_b;
        acc_d   = '0;
        cnt_d   = '0;
`else
        state_d   = DONE;
        out_d     = '0;
        illegal_d = 1'b1;
`endif
      end else begin
        state_d   = DONE;
        out_d     = base_ill ? '0 : base_res;
        illegal_d = base_ill;
      end
    end
    if (bus.i_kill) begin
      state_d = IDLE;
`ifdef RISCV_ALU_MULDIV_EN
      opnd_d = '0;
      acc_d  = '0;
      cnt_d  = '0;
`endif
    end
  end

  // State and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef RISCV_ALU_MULDIV_EN
  // Multiply/divide operand and iteration registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f3_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      f3_q   <= f3_d;
      a_q    <= a_d;
      b_q    <= b_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end
`endif
endmodule
